// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type, constants and packed-port slice helper
package regfile_pkg;
    typedef enum logic {CLEAR, READY} state_t;
    localparam int ZERO_ADDR = 0;
    function automatic int lo(input int idx, input int w);
        return idx * w;
    endfunction
endpackage

// File: rtl/regfile_rd_mux.sv
// regfile_rd_mux: one read port with write bypass, zero-register rule and clear gating
module regfile_rd_mux
    import regfile_pkg::*;
#(
    parameter int AW       = 5,
    parameter int DW       = 32,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                 i_ready,
    input  logic [AW-1:0]        i_raddr,
    input  logic [NUM_WR-1:0]    i_wen,
    input  logic [NUM_WR*AW-1:0] i_waddr,
    input  logic [NUM_WR*DW-1:0] i_wdata,
    input  logic [DW-1:0]        i_stored,
    output logic [DW-1:0]        o_rdata
);
    always_comb begin
        o_rdata = i_stored;
        // ascending scan lets the highest-index matching port win
        if (BYPASS != 0)
            for (int k = 0; k < NUM_WR; k++)
                if (i_wen[k] && i_waddr[lo(k, AW) +: AW] == i_raddr)
                    o_rdata = i_wdata[lo(k, DW) +: DW];
        if (!i_ready || (ZERO_REG != 0 && i_raddr == AW'(ZERO_ADDR)))
            o_rdata = '0;
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port RV32I register file with sequenced clear, bypass and debug port
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_clr_req,
    input  logic [NUM_WR-1:0]            i_wen,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] i_waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] i_wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rdata,
    input  logic [ADDR_WIDTH-1:0]        i_dbg_addr,
    output logic [DATA_WIDTH-1:0]        o_dbg_data,
    output logic                         o_ready
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH:0]   r_clr_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_ready, w_last;
    assign w_ready = r_state == READY;
    assign w_last  = r_clr_cnt == (ADDR_WIDTH + 1)'(DEPTH - 1);
    assign o_ready = w_ready;
    always_comb begin
        w_state_nxt = w_ready ? (i_clr_req ? CLEAR : READY) : (w_last ? READY : CLEAR);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_ready ? '0 : r_clr_cnt + 1'b1;
        end
    end
    // storage is not reset; the clear sequence is what zeroes it
    always_ff @(posedge i_clk) begin
        if (!w_ready)
            r_mem[r_clr_cnt[ADDR_WIDTH-1:0]] <= '0;
        else
            for (int k = 0; k < NUM_WR; k++)
                if (i_wen[k] && !(ZERO_REG != 0 && i_waddr[lo(k, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(ZERO_ADDR)))
                    r_mem[i_waddr[lo(k, ADDR_WIDTH) +: ADDR_WIDTH]] <= i_wdata[lo(k, DATA_WIDTH) +: DATA_WIDTH];
    end
    assign o_dbg_data = (!w_ready || (ZERO_REG != 0 && i_dbg_addr == ADDR_WIDTH'(ZERO_ADDR)))
                        ? '0 : r_mem[i_dbg_addr];
    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        regfile_rd_mux #(
            .AW(ADDR_WIDTH), .DW(DATA_WIDTH), .NUM_WR(NUM_WR), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
        ) u_rd (
            .i_ready (w_ready),
            .i_raddr (i_raddr[lo(r, ADDR_WIDTH) +: ADDR_WIDTH]),
            .i_wen   (i_wen),
            .i_waddr (i_waddr),
            .i_wdata (i_wdata),
            .i_stored(r_mem[i_raddr[lo(r, ADDR_WIDTH) +: ADDR_WIDTH]]),
            .o_rdata (o_rdata[lo(r, DATA_WIDTH) +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two configurations (2W bypass, 1W stored-read) against an array model
module tb_regfile_mp;
    logic        clk = 0, rst_n = 0, clr_req = 0;
    logic [1:0]  wen = 0;
    logic [9:0]  waddr = 0, raddr = 0;
    logic [63:0] wdata = 0, rd_a, rd_b;
    logic [4:0]  dbg_addr = 0;
    logic [31:0] dbg_a, dbg_b;
    logic        rdy_a, rdy_b;
    logic [31:0] ma [32], mb [32];
    int          clr_left, ntot = 0, npass = 0;

    always #5 clk = ~clk;

    regfile_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr_req(clr_req), .i_wen(wen), .i_waddr(waddr),
        .i_wdata(wdata), .i_raddr(raddr), .o_rdata(rd_a), .i_dbg_addr(dbg_addr),
        .o_dbg_data(dbg_a), .o_ready(rdy_a));
    regfile_mp #(.NUM_RD(2), .NUM_WR(1), .BYPASS(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr_req(clr_req), .i_wen(wen[0:0]), .i_waddr(waddr[4:0]),
        .i_wdata(wdata[31:0]), .i_raddr(raddr), .o_rdata(rd_b), .i_dbg_addr(dbg_addr),
        .o_dbg_data(dbg_b), .o_ready(rdy_b));

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        if (clr_left > 0 || a == 0) return 0;
        if (wen[1] && waddr[9:5] == a) return wdata[63:32];
        if (wen[0] && waddr[4:0] == a) return wdata[31:0];
        return ma[a];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] a);
        return (clr_left > 0 || a == 0) ? 32'h0 : mb[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wipe;
        for (int i = 0; i < 32; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
    endtask

    task automatic step;
        #1;
        chk("ready_a", {31'b0, rdy_a}, {31'b0, clr_left == 0});
        chk("ready_b", {31'b0, rdy_b}, {31'b0, clr_left == 0});
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rd_a%0d", p), rd_a[p*32 +: 32], exp_a(raddr[p*5 +: 5]));
            chk($sformatf("rd_b%0d", p), rd_b[p*32 +: 32], exp_b(raddr[p*5 +: 5]));
        end
        chk("dbg_a", dbg_a, (clr_left > 0 || dbg_addr == 0) ? 32'h0 : ma[dbg_addr]);
        chk("dbg_b", dbg_b, exp_b(dbg_addr));
        @(posedge clk);
        if (rst_n) begin
            if (clr_left > 0) clr_left--;
            else begin
                for (int k = 0; k < 2; k++)
                    if (wen[k] && waddr[k*5 +: 5] != 0) ma[waddr[k*5 +: 5]] = wdata[k*32 +: 32];
                if (wen[0] && waddr[4:0] != 0) mb[waddr[4:0]] = wdata[31:0];
                if (clr_req) begin
                    clr_left = 32;
                    wipe();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle;
        wen = 0;
        clr_req = 0;
    endtask

    task automatic rnd_in(input bit allow_clr);
        wen = 2'($urandom);
        waddr = 10'($urandom);
        wdata = {$urandom, $urandom};
        raddr = 10'($urandom);
        dbg_addr = 5'($urandom);
        if ($urandom_range(0, 3) == 0) waddr[9:5] = waddr[4:0];
        if ($urandom_range(0, 2) == 0) raddr[4:0] = waddr[9:5];
        if ($urandom_range(0, 2) == 0) raddr[9:5] = waddr[4:0];
        clr_req = allow_clr && $urandom_range(0, 49) == 0;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        wen = 2'b01;
        waddr = {5'd0, a};
        wdata = {32'h0, d};
    endtask

    task automatic sweep;
        idle();
        for (int a = 0; a < 32; a++) begin
            raddr = {5'(a), 5'(a ^ 31)};
            dbg_addr = 5'(a);
            step();
        end
    endtask

    task automatic async_reset;
        #2 rst_n = 0;
        clr_left = 32;
        wipe();
        idle();
        repeat (2) step();
        rst_n = 1;
        repeat (33) begin
            rnd_in(1);
            step();
        end
    endtask

    initial begin
        clr_left = 32;
        wipe();
        repeat (2) step();
        rst_n = 1;
        repeat (32) begin
            rnd_in(1);
            step();
        end
        idle();
        step();
        sweep();
        wr0(5, 32'hDEADBEEF);
        raddr = {5'd5, 5'd5};
        dbg_addr = 5;
        step();
        idle();
        step();
        wr0(7, 32'h12345678);
        raddr = {5'd1, 5'd7};
        step();
        idle();
        step();
        wr0(0, 32'hFFFFFFFF);
        raddr = {5'd0, 5'd0};
        dbg_addr = 0;
        step();
        idle();
        step();
        wen = 2'b11;
        waddr = {5'd3, 5'd3};
        wdata = {32'h5555, 32'hAAAA};
        raddr = {5'd3, 5'd3};
        dbg_addr = 3;
        step();
        idle();
        step();
        wr0(10, 32'd42);
        dbg_addr = 10;
        step();
        idle();
        step();
        for (int a = 1; a < 32; a++) begin
            wr0(5'(a), 32'(a));
            raddr = {5'(a - 1), 5'(a)};
            step();
        end
        wr0(9, 32'h99);
        clr_req = 1;
        raddr = {5'd9, 5'd9};
        dbg_addr = 9;
        step();
        repeat (32) begin
            rnd_in(0);
            step();
        end
        sweep();
        repeat (300) begin
            rnd_in(1);
            step();
        end
        idle();
        clr_req = 1;
        step();
        clr_req = 0;
        repeat (10) step();
        async_reset();
        repeat (100) begin
            rnd_in(1);
            step();
        end
        async_reset();
        sweep();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
